logic_unit_pipe: RTL

//   Parametrised, pipelined successor to the single-bit gate primitives block.

---
 rtl/logic_unit_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipeline applying one of eight
// bitwise logic ops to two WIDTH-bit operands.
// Ports:
//   iClk, iRst                 clock, synchronous active-high reset
//   iValid/oReady, iA, iB, iOp operand beat handshake and payload
//   oValid/iReady, oResult     result handshake and payload
//   oCount                     completed output transfers (wraps)
//   oZero, oOnes, oParity      result flags (LOGIC_UNIT_FLAGS_EN only)
// Optional feature macro: LOGIC_UNIT_FLAGS_EN
module logic_unit_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iValid,
    output logic               oReady,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    input  logic [2:0]         iOp,
    output logic               oValid,
    input  logic               iReady,
    output logic [WIDTH-1:0]   oResult,
    output logic [COUNT_W-1:0] oCount
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic               oZero,
    output logic               oOnes,
    output logic               oParity
`endif
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    logic             s1Valid;
    logic [WIDTH-1:0] s1A;
    logic [WIDTH-1:0] s1B;
    logic [2:0]       s1Op;

    logic             s2Load;
    logic             s1Advance;
    logic             inXfer;
    logic             outXfer;
    logic [WIDTH-1:0] aluResult;

    // Stage 2 frees up either when empty or when its beat leaves this cycle,
    // so oReady can look through a full pipeline to iReady.
    assign outXfer   = oValid && iReady;
    assign s2Load    = !oValid || iReady;
    assign s1Advance = s1Valid && s2Load;
    assign oReady    = !s1Valid || s1Advance;
    assign inXfer    = iValid && oReady;

    always_comb begin
        aluResult = '0;
        case (s1Op)
            OP_AND:  aluResult = s1A & s1B;
            OP_OR:   aluResult = s1A | s1B;
            OP_NOTA: aluResult = ~s1A;
            OP_NAND: aluResult = ~(s1A & s1B);
            OP_NOR:  aluResult = ~(s1A | s1B);
            OP_XOR:  aluResult = s1A ^ s1B;
            OP_XNOR: aluResult = ~(s1A ^ s1B);
            OP_PASS: aluResult = s1A;
            default: aluResult = '0;
        endcase
    end

    // Stage 1: operand register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1Valid <= 1'b0;
            s1A     <= '0;
            s1B     <= '0;
            s1Op    <= '0;
        end else if (inXfer) begin
            s1Valid <= 1'b1;
            s1A     <= iA;
            s1B     <= iB;
            s1Op    <= iOp;
        end else if (s1Advance) begin
            s1Valid <= 1'b0;
        end
    end

    // Stage 2: result register; payload keeps its last value when emptied
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oValid  <= 1'b0;
            oResult <= '0;
        end else if (s2Load) begin
            oValid <= s1Valid;
            if (s1Valid) begin
                oResult <= aluResult;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oCount <= '0;
        end else if (outXfer) begin
            oCount <= oCount + COUNT_W'(1);
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    // Flags travel with oResult so they share its stall/hold behaviour.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oZero   <= 1'b0;
            oOnes   <= 1'b0;
            oParity <= 1'b0;
        end else if (s2Load && s1Valid) begin
            oZero   <= (aluResult == '0);
            oOnes   <= (aluResult == '1);
            oParity <= ^aluResult;
        end
    end
`endif

endmodule
